// File: rtl/alu_pkg.sv
// Shared types for the chunked sequential ALU: opcode and FSM state encodings.
// Optional signed-overflow output is enabled by defining ALU_OVF_EN.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_NOR = 2'b00,
        OP_XOR = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } alu_state_t;

    // Arithmetic ops are the ones with the top opcode bit set.
    function automatic logic is_arith(input alu_op_t op);
        return op[1];
    endfunction

endpackage

// File: rtl/alu_chunk.sv
// Combinational CHUNK-wide ALU slice (NOR/XOR/ADD/SUB); ALU_OVF_EN adds c_msb output.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the parent FSM sequences it one chunk per cycle.
module alu_chunk
    import alu_pkg::*;
#(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    input  alu_op_t          op,
    output logic [CHUNK-1:0] s,
`ifdef ALU_OVF_EN
    output logic             c_msb,
`endif
    output logic             cout
);

    logic [CHUNK-1:0] bx;
    logic [CHUNK:0]   sum;

    assign bx  = (op == OP_SUB) ? ~b : b;
    assign sum = {1'b0, a} + {1'b0, bx} + {{CHUNK{1'b0}}, cin};

`ifdef ALU_OVF_EN
    // Carry into the top bit recovered from the sum bit and its two addend bits.
    assign c_msb = is_arith(op) & (sum[CHUNK-1] ^ a[CHUNK-1] ^ bx[CHUNK-1]);
`endif

    always_comb begin
        s    = '0;
        cout = 1'b0;
        case (op)
            OP_NOR: s = ~(a | b);
            OP_XOR: s = a ^ b;
            default: begin
                s    = sum[CHUNK-1:0];
                cout = sum[CHUNK];
            end
        endcase
    end

endmodule

// File: rtl/alu_seq_chunked.sv
// Multi-cycle WIDTH-bit ALU processing CHUNK bits per cycle; ALU_OVF_EN adds the ovf port.
// Latency: out_valid rises WIDTH/CHUNK cycles after the accepting edge.
// Backpressure: result held in DONE while out_ready=0; in_ready low from accept until handshake.
module alu_seq_chunked
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
`ifdef ALU_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("alu_seq_chunked: WIDTH must be a positive multiple of CHUNK");
    end

    alu_state_t       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    alu_op_t          op_q;
    logic             carry_q;
    logic [IDXW-1:0]  idx;

    logic [CHUNK-1:0] ch_s;
    logic             ch_cout;
`ifdef ALU_OVF_EN
    logic             ch_cmsb;
`endif

    // One slice shared by all chunks; the operand registers are muxed by idx.
    alu_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_q[idx*CHUNK +: CHUNK]),
        .b     (b_q[idx*CHUNK +: CHUNK]),
        .cin   (carry_q),
        .op    (op_q),
        .s     (ch_s),
`ifdef ALU_OVF_EN
        .c_msb (ch_cmsb),
`endif
        .cout  (ch_cout)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_NOR;
            carry_q <= 1'b0;
            idx     <= '0;
            s       <= '0;
            cout    <= 1'b0;
`ifdef ALU_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= alu_op_t'(op);
                        carry_q <= is_arith(alu_op_t'(op)) & cin;
                        idx     <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    s[idx*CHUNK +: CHUNK] <= ch_s;
                    carry_q <= ch_cout;
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        cout  <= ch_cout;
`ifdef ALU_OVF_EN
                        ovf   <= ch_cmsb ^ ch_cout;
`endif
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_chunked.sv
// Self-checking bench for alu_seq_chunked: directed corner cases plus random ops against a 65-bit arithmetic model.
module tb_alu_seq_chunked;

    localparam int W   = 64;
    localparam int C   = 16;
    localparam int NCH = W / C;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
`ifdef ALU_OVF_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_seq_chunked #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
`ifdef ALU_OVF_EN
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: whole-word arithmetic, overflow from operand/result signs.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mcin,
                         input logic [1:0] mop, output logic [W-1:0] ms, output logic mc,
                         output logic mo);
        logic [W:0]   r;
        logic [W-1:0] bx;
        bx = (mop == 2'b11) ? ~mb : mb;
        r  = {1'b0, ma} + {1'b0, bx} + W'(mcin);
        mo = 1'b0;
        case (mop)
            2'b00:   begin ms = ~(ma | mb); mc = 1'b0; end
            2'b01:   begin ms = ma ^ mb;    mc = 1'b0; end
            default: begin
                ms = r[W-1:0];
                mc = r[W];
                mo = (ma[W-1] == bx[W-1]) && (ms[W-1] != ma[W-1]);
            end
        endcase
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                          input logic [1:0] top, input int hold);
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
        int           lat;
        int           wait_cnt;
        model(ta, tb, tcin, top, es, ec, eo);
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("in_ready_before_op", 64'(in_ready), 64'd1);
        a = ta; b = tb; cin = tcin; op = top; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom); op = 2'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            chk("in_ready_busy", 64'(in_ready), 64'd0);
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(NCH));
        chk("s", s, es);
        chk("cout", 64'(cout), 64'(ec));
`ifdef ALU_OVF_EN
        chk("ovf", 64'(ovf), 64'(eo));
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_s", s, es);
            chk("hold_cout", 64'(cout), 64'(ec));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_hs", 64'(out_valid), 64'd0);
        chk("in_ready_after_hs", 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = 2'b00; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_s", s, 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
`ifdef ALU_OVF_EN
        chk("rst_ovf", 64'(ovf), 64'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        run_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 2'b10, 0);
        run_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 2'b11, 0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 2'b10, 0);
        run_op(64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1, 2'b00, 0);
        run_op(64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1, 2'b01, 0);
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 2'b11, 10);

        // Abandon an op mid-flight once idx has reached 2.
        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; cin = 1'b0; op = 2'b10; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_s", s, 64'd0);
        chk("midrst_cout", 64'(cout), 64'd0);
        repeat (NCH + 2) begin
            @(negedge clk);
            chk("midrst_no_result", 64'(out_valid), 64'd0);
        end
        run_op(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, 2'b10, 1);

        for (int k = 0; k < 40; k++) begin
            run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 2'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
